// File: rtl/ofdm_rx_byte_packer.sv
// Packs demodulated OFDM symbols LSB-first into bytes and buffers them in a
// show-ahead FIFO presented on a ready/valid byte interface.
module ofdm_rx_byte_packer #(
    parameter int unsigned symbol_bits_g = 2,
    parameter int unsigned fifo_depth_g  = 16
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            sys_init,
    input  logic [symbol_bits_g-1:0]        rx_rcv_data,
    input  logic                            rx_rcv_data_valid,
    input  logic                            rx_rcv_data_start,
    output logic [7:0]                      byte_data,
    output logic                            byte_sof,
    output logic                            byte_valid,
    input  logic                            byte_ready,
    output logic [$clog2(fifo_depth_g):0]   fifo_level,
    output logic                            overflow,
    output logic                            partial_drop
);

    localparam int unsigned SymPerByte = 8 / symbol_bits_g;
    localparam int unsigned CntW       = (SymPerByte > 1) ? $clog2(SymPerByte) : 1;
    localparam int unsigned AddrW      = $clog2(fifo_depth_g);
    localparam int unsigned LvlW       = AddrW + 1;
    localparam logic [7:0]  SymMask    = 8'((32'd1 << symbol_bits_g) - 32'd1);

    logic                 rst;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [7:0]           acc_q, acc_d;
    logic                 active_q, active_d;
    logic                 sof_pend_q, sof_pend_d;
    logic                 pdrop_q, pdrop_d;
    logic                 ovf_q, ovf_d;
    logic                 push, push_sof, last;
    logic [7:0]           push_byte, sym8;
    logic [2:0]           offset;
    logic                 pop, accept;
    logic [8:0]           mem_q [fifo_depth_g];
    logic [AddrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [LvlW-1:0]      level_q, level_d;

    assign rst  = sys_rst | sys_init;
    assign sym8 = 8'(rx_rcv_data);

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        active_d   = active_q;
        sof_pend_d = sof_pend_q;
        pdrop_d    = 1'b0;
        push       = 1'b0;
        push_byte  = acc_q;
        push_sof   = sof_pend_q;
        last       = 1'b0;
        offset     = 3'(cnt_q * symbol_bits_g);
        // Symbols outside a frame are dropped until a start arrives.
        if (rx_rcv_data_valid && (rx_rcv_data_start || active_q)) begin
            if (rx_rcv_data_start) begin
                active_d   = 1'b1;
                sof_pend_d = 1'b1;
                pdrop_d    = active_q && (cnt_q != '0);
                acc_d      = sym8;
                cnt_d      = CntW'(1);
                last       = (SymPerByte == 1);
            end else begin
                acc_d = (acc_q & ~(SymMask << offset)) | (sym8 << offset);
                cnt_d = cnt_q + CntW'(1);
                last  = (cnt_q == CntW'(SymPerByte - 1));
            end
            if (last) begin
                push       = 1'b1;
                push_byte  = acc_d;
                push_sof   = rx_rcv_data_start | sof_pend_q;
                cnt_d      = '0;
                sof_pend_d = 1'b0;
            end
        end
    end

    always_comb begin
        pop     = (level_q != '0) && byte_ready;
        // A full FIFO still takes a byte when the head leaves on the same edge.
        accept  = push && ((level_q < LvlW'(fifo_depth_g)) || pop);
        level_d = level_q + LvlW'(accept) - LvlW'(pop);
        ovf_d   = ovf_q | (push & ~accept);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            active_q   <= 1'b0;
            sof_pend_q <= 1'b0;
            pdrop_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            active_q   <= active_d;
            sof_pend_q <= sof_pend_d;
            pdrop_q    <= pdrop_d;
            ovf_q      <= ovf_d;
            level_q    <= level_d;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept && !rst) begin
            mem_q[wr_ptr_q] <= {push_sof, push_byte};
        end
    end

    always_comb begin
        byte_valid   = (level_q != '0);
        byte_data    = byte_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
        byte_sof     = byte_valid ? mem_q[rd_ptr_q][8] : 1'b0;
        fifo_level   = level_q;
        overflow     = ovf_q;
        partial_drop = pdrop_q;
    end

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Directed and random stimulus for ofdm_rx_byte_packer, checked every cycle
// against a queue-based model of frames, bytes and the bounded FIFO.
module tb_ofdm_rx_byte_packer;

    localparam int unsigned SB    = 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SPB   = 8 / SB;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          sys_init = 1'b0;
    logic [SB-1:0] rx_rcv_data = '0;
    logic          rx_rcv_data_valid = 1'b0;
    logic          rx_rcv_data_start = 1'b0;
    logic [7:0]    byte_data;
    logic          byte_sof;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic          overflow;
    logic          partial_drop;

    always #5 sys_clk = ~sys_clk;

    ofdm_rx_byte_packer #(
        .symbol_bits_g(SB),
        .fifo_depth_g (DEPTH)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .sys_init         (sys_init),
        .rx_rcv_data      (rx_rcv_data),
        .rx_rcv_data_valid(rx_rcv_data_valid),
        .rx_rcv_data_start(rx_rcv_data_start),
        .byte_data        (byte_data),
        .byte_sof         (byte_sof),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .partial_drop     (partial_drop)
    );

    // Model state: buffered {sof, byte} entries and symbols of the byte in progress.
    logic [8:0] mq[$];
    int         syms[$];
    bit         m_active, m_first, m_ovf, m_pd;
    int         passes = 0;
    int         total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic void model_edge(input bit v, input bit s, input int d, input bit r,
                                       input bit rs);
        bit         pop;
        bit         do_push;
        int         pre;
        int         b;
        logic [8:0] ent;
        if (rs) begin
            mq.delete();
            syms.delete();
            m_active = 0;
            m_first  = 0;
            m_ovf    = 0;
            m_pd     = 0;
            return;
        end
        pre     = mq.size();
        pop     = (pre > 0) && r;
        do_push = 0;
        ent     = '0;
        m_pd    = 0;
        if (v && (s || m_active)) begin
            if (s) begin
                m_pd = m_active && (syms.size() > 0);
                syms.delete();
                m_active = 1;
                m_first  = 1;
            end
            syms.push_back(d);
            if (syms.size() == SPB) begin
                b = 0;
                foreach (syms[i]) b += syms[i] * (1 << (i * SB));
                ent     = {m_first, 8'(b)};
                do_push = 1;
                m_first = 0;
                syms.delete();
            end
        end
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (pre < DEPTH || pop) mq.push_back(ent);
            else m_ovf = 1;
        end
    endfunction

    task automatic check_all();
        bit ne;
        ne = (mq.size() > 0);
        chk("byte_valid", byte_valid, ne);
        chk("byte_data", byte_data, ne ? mq[0][7:0] : 8'h00);
        chk("byte_sof", byte_sof, ne ? mq[0][8] : 1'b0);
        chk("fifo_level", fifo_level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("partial_drop", partial_drop, m_pd);
    endtask

    task automatic cyc(input bit v, input bit s, input logic [SB-1:0] d, input bit r,
                       input bit rs = 0, input bit ini = 0);
        rx_rcv_data_valid = v;
        rx_rcv_data_start = s;
        rx_rcv_data       = d;
        byte_ready        = r;
        sys_rst           = rs;
        sys_init          = ini;
        @(posedge sys_clk);
        model_edge(v, s, int'(d), r, rs | ini);
        #1;
        check_all();
    endtask

    // Symbol i of the sequence is pat[i*SB +: SB]; start marks the first one.
    task automatic frame(input logic [31:0] pat, input int n, input bit st, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b1, st && (i == 0), pat[i*SB +: SB], r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, r);
    endtask

    initial begin
        // Reset values
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("rst_level", fifo_level, 0);

        // 1,2,3,0 -> 0x39 with sof, visible one cycle after the last symbol
        frame(32'h39, 4, 1'b1, 1'b1);
        chk("tp1_byte", byte_data, 8'h39);
        chk("tp1_sof", byte_sof, 1'b1);
        idle(3, 1'b1);
        chk("tp1_drained", fifo_level, 0);

        // 3,3,3,3,0,1,0,1 held -> 0xFF(sof) then 0x44
        frame(32'h44FF, 8, 1'b1, 1'b0);
        chk("tp2_level", fifo_level, 2);
        chk("tp2_head", byte_data, 8'hFF);
        idle(4, 1'b1);

        // Symbols outside a frame are ignored
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        frame(32'hA, 2, 1'b0, 1'b1);
        chk("tp3_nobyte", byte_valid, 1'b0);
        frame(32'h55, 4, 1'b1, 1'b0);
        chk("tp3_byte", byte_data, 8'h55);
        idle(3, 1'b1);

        // Restart mid-byte drops the partial byte
        frame(32'h5, 2, 1'b1, 1'b1);
        frame(32'h0, 4, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Overflow: 17 bytes into a 16-deep FIFO
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++) frame(32'(k * 7 + 3), 4, k == 0, 1'b0);
        chk("tp5_level", fifo_level, DEPTH);
        chk("tp5_ovf", overflow, 1'b1);
        idle(20, 1'b1);
        chk("tp5_ovf_sticky", overflow, 1'b1);

        // Reset with 5 buffered bytes, then a fresh frame
        for (int k = 0; k < 5; k++) frame(32'(k + 16), 4, k == 0, 1'b0);
        chk("tp6_level", fifo_level, 5);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("tp6_rst_valid", byte_valid, 1'b0);
        frame(32'h39, 4, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Random traffic including restarts and backpressure
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                SB'($urandom_range(0, (1 << SB) - 1)), $urandom_range(0, 9) < 5);
        end
        idle(DEPTH + 2, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/ofdm_rx_byte_packer.md
Name: ofdm_rx_byte_packer

Overview:
Downstream stage of the OFDM RX path. It consumes the demodulated symbol stream (rx_rcv_data / rx_rcv_data_valid / rx_rcv_data_start) and packs the symbols LSB-first into bytes. Packed bytes are buffered in a FIFO and presented on a ready/valid byte interface to the MAC/host side. It also reports frame-start alignment, fill level, overflow and partial-byte drops.

Parameters:
symbol_bits_g, 2, bits per demodulated symbol; legal values are 1, 2, 4, 8.
fifo_depth_g, 16, FIFO depth in bytes; must be a power of 2 and at least 2.

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
sys_init  in  1  synchronous soft init; same effect as sys_rst
rx_rcv_data  in  symbol_bits_g  demodulated symbol bits
rx_rcv_data_valid  in  1  symbol qualifier, one cycle per symbol
rx_rcv_data_start  in  1  first symbol of a frame; sampled only when valid=1
byte_data  out  8  packed byte at FIFO head
byte_sof  out  1  head byte is the first byte of a frame
byte_valid  out  1  head byte is available
byte_ready  in  1  consumer accepts the head byte when valid&ready
fifo_level  out  $clog2(fifo_depth_g)+1  bytes currently stored
overflow  out  1  sticky; a completed byte was discarded because the FIFO was full
partial_drop  out  1  one-cycle pulse; an incomplete byte was discarded on a new start

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst. sys_init acts identically to sys_rst.
- Reset / init values:
  - byte_valid=0, byte_sof=0, byte_data=0, fifo_level=0, overflow=0, partial_drop=0.
  - Symbol counter = 0, accumulator = 0, frame_active = 0.
  - FIFO contents are discarded.
  - Reset applied mid-operation drops everything, including buffered bytes, with no flush.
- Packing constants: SPB = 8/symbol_bits_g symbols per byte. The symbol counter cnt runs 0..SPB-1.
- When rx_rcv_data_valid=1 and rx_rcv_data_start=1:
  - frame_active <= 1.
  - Symbol written to bits [symbol_bits_g-1:0]; other accumulator bits are cleared; cnt <= 1; sof_pending <= 1.
  - If cnt != 0 and frame_active was already 1 before this start, partial_drop pulses high in the next cycle.
- When rx_rcv_data_valid=1, start=0 and frame_active=1: symbol written to bits [cnt*symbol_bits_g +: symbol_bits_g]; cnt increments.
- When rx_rcv_data_valid=1 and frame_active=0: the symbol is ignored and has no effect.
- Byte completion: when the symbol written is number SPB-1 (or SPB=1 with start), the assembled byte plus sof_pending is pushed into the FIFO on that same edge. Then cnt <= 0 and sof_pending <= 0.
  - Example, 2-bit symbols 1,2,3,0 give byte 0x39.
- FIFO: show-ahead (first-word fall-through). byte_data and byte_sof are valid whenever byte_valid=1.
  - Latency: a push on edge N into an empty FIFO gives byte_valid=1 in the cycle after edge N.
- Pop: occurs when byte_valid & byte_ready. The next entry, if any, appears in the following cycle. byte_ready while byte_valid=0 is ignored.
- Full: a push is accepted if fifo_level < fifo_depth_g, or if a pop happens on the same edge (level is unchanged).
  - Otherwise the byte, including its sof flag, is discarded and overflow <= 1. overflow stays set until sys_rst or sys_init.
- Simultaneous push and pop:
  - On an empty FIFO there is no bypass: the byte becomes visible one cycle later.
  - On a non-empty FIFO the level is unchanged.
- fifo_level is registered and reflects the state after the edge. Pointers wrap modulo fifo_depth_g.
- There is no backpressure toward the RX path; this block never stalls rx_rcv_data.
- The incoming symbol rate is at most one per cycle; consecutive-cycle valid must be supported.

Test Plan:
- Reset, then start+valid with symbols 1,2,3,0 on four consecutive cycles, byte_ready=1 -> one byte 0x39 with byte_sof=1, byte_valid for exactly 1 cycle, appearing 1 cycle after the 4th symbol; fifo_level returns to 0.
- 8 symbols 3,3,3,3,0,1,0,1 (start on first), byte_ready=0 -> fifo_level=2. Head is 0xFF with sof=1, then 0x44 with sof=0. Raise ready -> both drain in order.
- Symbols 2,2 with valid but no start after reset -> no byte and no partial_drop. Then start with 1,1,1,1 -> byte 0x55 with sof=1.
- Start, symbols 1,1, then a new start with 0,0,0,0 -> partial_drop pulses once. Output is only 0x00 with sof=1.
- byte_ready=0, push 17 bytes -> fifo_level=16, overflow=1 after the 17th. Release ready -> exactly 16 bytes drain in push order, and overflow stays 1.
- FIFO holding 5 bytes, assert sys_rst for 1 cycle -> next cycle byte_valid=0, fifo_level=0, overflow=0. A subsequent start-aligned frame packs correctly.
